sha256_msg_schedule: RTL and testbench

//  Downstream of the SPI slave: accepts one 512-bit message block, as assembled from MOSI, over a valid/ready handshake.

---
 rtl/sha256_pkg.sv | 40 ++++
 rtl/sha256_msg_schedule.sv | 117 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sigma helpers and the round-constant table.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned BLOCK_W  = 512;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned WIN_LEN  = 16;

    // Small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // Small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Round constants, consumed by the compression-round stage
    localparam word_t K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: takes one 512-bit block, streams W[0..ROUNDS-1].
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blk_valid,
    input  logic [0:BLOCK_W-1] blk_data,
    output logic               blk_ready,
    input  logic               flush,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [31:0]        w_data,
    output logic [5:0]         w_idx,
    output logic               w_last
);

    localparam int unsigned    IDX_W    = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] t_q, t_d;
    word_t            win_q [WIN_LEN];
    word_t            win_d [WIN_LEN];
    logic             blk_ready_q, blk_ready_d;
    logic             w_valid_q, w_valid_d;
    logic             w_last_q, w_last_d;
    word_t            w_new;
    logic             beat;

    // Next schedule word W[t+16] from the current 16-word window
    always_comb begin
        w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    end

    // Next-state, window and registered-output logic
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        win_d       = win_q;
        blk_ready_d = blk_ready_q;
        w_valid_d   = w_valid_q;
        w_last_d    = w_last_q;
        beat        = w_valid_q && w_ready;

        if (flush) begin
            state_d = ST_IDLE;
            t_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (blk_valid && blk_ready_q) begin
                        for (int i = 0; i < int'(WIN_LEN); i++) begin
                            win_d[i] = blk_data[WORD_W*i +: WORD_W];
                        end
                        t_d     = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        if (t_q == LAST_IDX) begin
                            t_d     = '0;
                            state_d = ST_IDLE;
                        end else begin
                            for (int i = 0; i < int'(WIN_LEN) - 1; i++) begin
                                win_d[i] = win_q[i+1];
                            end
                            win_d[WIN_LEN-1] = w_new;
                            t_d              = t_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        blk_ready_d = (state_d == ST_IDLE);
        w_valid_d   = (state_d == ST_RUN);
        w_last_d    = (state_d == ST_RUN) && (t_d == LAST_IDX);
    end

    // State, counter, window and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            t_q         <= '0;
            blk_ready_q <= 1'b1;
            w_valid_q   <= 1'b0;
            w_last_q    <= 1'b0;
            for (int i = 0; i < int'(WIN_LEN); i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            blk_ready_q <= blk_ready_d;
            w_valid_q   <= w_valid_d;
            w_last_q    <= w_last_d;
            win_q       <= win_d;
        end
    end

    assign blk_ready = blk_ready_q;
    assign w_valid   = w_valid_q;
    assign w_data    = win_q[0];
    assign w_idx     = t_q;
    assign w_last    = w_last_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule (ROUNDS=64 and ROUNDS=16 instances).
module tb_sha256_msg_schedule;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid, flush, w_ready;
    logic [0:511] blk_data;
    logic         blk_ready, w_valid, w_last;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;

    logic         b16_valid, flush16, w_ready16;
    logic [0:511] b16_data;
    logic         b16_ready, w16_valid, w16_last;
    logic [31:0]  w16_data;
    logic [5:0]   w16_idx;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q_main [$];
    exp_t q16 [$];
    logic [31:0] obs_w [64];
    int last_cnt = 0;
    int last16_cnt = 0;

    logic         stall_prev = 1'b0;
    logic [31:0]  prev_data;
    logic [5:0]   prev_idx;
    logic         prev_last;

    logic [0:511] blk_abc, blk_b2, blk_b3, blk_ones;

    always #5 clk = ~clk;

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid), .blk_data(blk_data),
        .blk_ready(blk_ready), .flush(flush), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .w_idx(w_idx), .w_last(w_last)
    );

    sha256_msg_schedule #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .blk_valid(b16_valid), .blk_data(b16_data),
        .blk_ready(b16_ready), .flush(flush16), .w_valid(w16_valid), .w_ready(w_ready16),
        .w_data(w16_data), .w_idx(w16_idx), .w_last(w16_last)
    );

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule: classic full-array recurrence W[t] from W[t-2,t-7,t-15,t-16]
    function automatic logic [31:0] sched_word(input logic [0:511] b, input int t);
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = b[32*i +: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        return w[t];
    endfunction

    // Expected-word producers: on each accepted block, queue its schedule
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready && !flush) begin
            for (int t = 0; t < 64; t++)
                q_main.push_back('{data: sched_word(blk_data, t), idx: 6'(t), last: (t == 63)});
        end
        if (rst_n && b16_valid && b16_ready && !flush16) begin
            for (int t = 0; t < 16; t++)
                q16.push_back('{data: sched_word(b16_data, t), idx: 6'(t), last: (t == 15)});
        end
    end

    // Monitor for the 64-round instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            chk(blk_ready == !w_valid, "ready_vs_valid", 32'(blk_ready), 32'(!w_valid));
            if (stall_prev) begin
                chk(w_valid && w_data == prev_data && w_idx == prev_idx && w_last == prev_last,
                    "stall_hold", w_data, prev_data);
            end
            if (w_valid && w_ready && !flush) begin
                if (q_main.size() == 0) begin
                    chk(1'b0, "unexpected_word", 32'(w_idx), 32'hFFFFFFFF);
                end else begin
                    e = q_main.pop_front();
                    chk(w_data == e.data, "w_data", w_data, e.data);
                    chk(w_idx == e.idx, "w_idx", 32'(w_idx), 32'(e.idx));
                    chk(w_last == e.last, "w_last", 32'(w_last), 32'(e.last));
                    obs_w[w_idx] = w_data;
                    if (w_last) last_cnt++;
                end
            end
            stall_prev = w_valid && !w_ready && !flush;
            prev_data  = w_data;
            prev_idx   = w_idx;
            prev_last  = w_last;
        end
    end

    // Monitor for the 16-round instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && w16_valid && w_ready16 && !flush16) begin
            if (q16.size() == 0) begin
                chk(1'b0, "unexpected_word16", 32'(w16_idx), 32'hFFFFFFFF);
            end else begin
                e = q16.pop_front();
                chk(w16_data == e.data, "w16_data", w16_data, e.data);
                chk(w16_idx == e.idx, "w16_idx", 32'(w16_idx), 32'(e.idx));
                chk(w16_last == e.last, "w16_last", 32'(w16_last), 32'(e.last));
                if (w16_last) last16_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block on the 64-round instance until accepted
    task automatic send_block(input logic [0:511] d);
        int n = 0;
        blk_valid = 1'b1;
        blk_data  = d;
        while (!blk_ready && n < 200) begin tick(); n++; end
        if (!blk_ready) chk(1'b0, "send_timeout", 32'(n), 32'd0);
        tick();
        blk_valid = 1'b0;
    endtask

    // Run until the scoreboard drains and the DUT returns to IDLE
    task automatic wait_done(input bit rand_ready);
        int n = 0;
        while ((q_main.size() != 0 || w_valid) && n < 3000) begin
            if (rand_ready) w_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        w_ready = 1'b1;
        chk(q_main.size() == 0 && !w_valid, "drain_timeout", 32'(q_main.size()), 32'd0);
    endtask

    task automatic wait_idx(input logic [5:0] target);
        int n = 0;
        while (!(w_valid && w_idx == target) && n < 500) begin tick(); n++; end
        chk(w_valid && w_idx == target, "idx_reach", 32'(w_idx), 32'(target));
    endtask

    initial begin
        blk_abc = '0;
        blk_abc[0:31]    = 32'h61626380;
        blk_abc[480:511] = 32'h00000018;
        for (int i = 0; i < 16; i++) begin
            blk_b2[32*i +: 32] = 32'h01000193 * 32'(i + 1) ^ 32'hA5A5_0000;
            blk_b3[32*i +: 32] = {16'(i), 16'hBEEF};
        end
        blk_ones = '1;

        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; flush = 1'b0; w_ready = 1'b0;
        b16_valid = 1'b0; b16_data = '0; flush16 = 1'b0; w_ready16 = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk(!w_valid && w_data == 32'd0 && w_idx == 6'd0 && !w_last, "reset_outputs", w_data, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk(blk_ready == 1'b1, "reset_blk_ready", 32'(blk_ready), 32'd1);
        chk(!w_valid, "reset_w_valid", 32'(w_valid), 32'd0);
        tick();

        // 1: "abc" block, consumer always ready
        w_ready = 1'b1;
        send_block(blk_abc);
        chk(w_valid && w_idx == 6'd0 && w_data == 32'h61626380, "first_word_latency", w_data, 32'h61626380);
        wait_done(1'b0);
        chk(obs_w[16] == 32'h61626380, "abc_W16", obs_w[16], 32'h61626380);
        chk(obs_w[17] == 32'h000F0000, "abc_W17", obs_w[17], 32'h000F0000);
        chk(last_cnt == 1, "last_count", 32'(last_cnt), 32'd1);

        // 2: same block, random back-pressure
        send_block(blk_abc);
        wait_done(1'b1);
        chk(last_cnt == 2, "last_count2", 32'(last_cnt), 32'd2);

        // 3: blk_valid held high; data changed while busy
        blk_valid = 1'b1;
        blk_data  = blk_abc;
        tick();
        blk_data  = blk_b2;
        begin
            int n = 0;
            while (!(w_valid && w_last) && n < 200) begin tick(); n++; end
        end
        chk(w_valid && w_last, "reach_last", 32'(w_idx), 32'd63);
        tick();
        chk(blk_ready && !w_valid, "idle_gap", {30'd0, blk_ready, w_valid}, 32'h2);
        tick();
        blk_valid = 1'b0;
        chk(w_valid && w_idx == 6'd0 && !blk_ready, "second_accept", 32'(w_idx), 32'd0);
        wait_done(1'b0);

        // 4: flush at idx 20 with w_ready high
        send_block(blk_b3);
        wait_idx(6'd20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        q_main.delete();
        chk(!w_valid && blk_ready, "flush_idle", {30'd0, blk_ready, w_valid}, 32'h2);
        send_block(blk_b2);
        chk(w_valid && w_idx == 6'd0, "restart_idx", 32'(w_idx), 32'd0);
        wait_done(1'b0);

        // 5: asynchronous reset at idx 40
        send_block(blk_abc);
        wait_idx(6'd40);
        #2 rst_n = 1'b0;
        #1;
        chk(!w_valid && w_data == 32'd0 && w_idx == 6'd0 && !w_last, "async_reset", w_data, 32'd0);
        q_main.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk(!w_valid, "no_words_after_reset", 32'(w_valid), 32'd0);
        end
        send_block(blk_b3);
        wait_done(1'b1);

        // 6: ROUNDS=16, all-ones block
        b16_valid = 1'b1;
        b16_data  = blk_ones;
        tick();
        b16_valid = 1'b0;
        begin
            int n = 0;
            while ((q16.size() != 0 || w16_valid) && n < 200) begin tick(); n++; end
        end
        chk(q16.size() == 0 && !w16_valid && b16_ready, "r16_idle", 32'(q16.size()), 32'd0);
        chk(last16_cnt == 1, "r16_last_count", 32'(last16_cnt), 32'd1);

        chk(q_main.size() == 0, "queue_empty", 32'(q_main.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
